bf2_bundle_serializer: RTL and testbench
========================================

BF2_BUNDLE_SERIALIZER -- requirements
Module: bf2_bundle_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning signed sample width per lane (butterfly output width).
REQ-002 SHALL have parameter DEPTH, default 16, meaning lanes per bundle; it is a power of two, >= 2.
REQ-003 SHALL have parameter BITREV, default 0, meaning 1 = emit lanes in bit-reversed index order, 0 = natural order.
REQ-004 SHALL have ports as follows, one per line.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream bundle present.
- in_ready  output  1  a free bundle slot exists.
- in_R  input  signed WIDTH x DEPTH (unpacked array)  real lanes of the bundle.
- in_Q  input  signed WIDTH x DEPTH (unpacked array)  imaginary lanes of the bundle.
- out_valid  output  1  serial sample present.
- out_ready  input  1  downstream accepts sample.
- out_R  output  signed WIDTH  real part of current sample.
- out_Q  output  signed WIDTH  imaginary part of current sample.
- out_idx  output  log2(DEPTH)  lane index of current sample (after any bit reversal).
- out_last  output  1  current sample is the final one of its bundle.
- ovf  output  1  sticky: bundle offered while no slot was free.

Function
REQ-005 SHALL hold two bundle slots (ping-pong), each storing DEPTH R/Q pairs, plus a per-slot full flag, a write pointer, a read pointer and a serial counter cnt (0..DEPTH-1).
REQ-006 SHALL drive in_ready = 1 when at least one slot is empty, computed from registered state only; no combinational path from out_ready to in_ready.
REQ-007 SHALL, on a rising edge with in_valid && in_ready, copy all DEPTH lanes of in_R/in_Q into the slot at the write pointer, set its full flag and toggle the write pointer.
REQ-008 SHALL drive out_valid = full flag of the slot at the read pointer.
REQ-009 SHALL drive out_idx = cnt when BITREV = 0, and = bit-reverse of cnt over log2(DEPTH) bits when BITREV = 1.
REQ-010 SHALL drive out_R/out_Q = the stored lane out_idx of the read slot; out_R/out_Q are 0 when out_valid = 0.
REQ-011 SHALL drive out_last = out_valid && (cnt == DEPTH-1).
REQ-012 SHALL, on a rising edge with out_valid && out_ready, increment cnt; if out_last, clear the read slot's full flag, toggle the read pointer and set cnt = 0.
REQ-013 SHALL hold out_R, out_Q, out_idx and out_last stable while out_valid && !out_ready.
REQ-014 SHALL give latency of one cycle: a bundle accepted into an empty block at edge N yields out_valid = 1 with lane index 0 (or bitrev(0) = 0) immediately after edge N.
REQ-015 SHALL sustain one bundle per DEPTH cycles with out_ready held high and in_valid offered whenever in_ready = 1, with no bubble between bundles.
REQ-016 SHALL permit a write and a final-sample read in the same edge; when both slots were full, in_ready stays 0 in that cycle and goes 1 after the edge.
REQ-017 SHALL, when both slots are full and in_valid = 1, ignore the input (no state change to storage) and set ovf = 1 at that edge; ovf clears only on reset.
REQ-018 SHALL treat data as pass-through: no arithmetic, no width change, sign preserved bit-exactly.

Reset
REQ-019 SHALL, while rst = 1 (asynchronously), clear both full flags, both pointers, cnt, ovf and all stored lanes to 0, giving in_ready = 1, out_valid = 0, out_R = out_Q = 0, out_idx = 0, out_last = 0.
REQ-020 SHALL, on reset asserted mid-bundle, discard any partially emitted and any buffered bundle; after release, the first accepted bundle starts from index 0.

Verification
REQ-021 SHALL pass this scenario: single bundle with in_R[k] = k, in_Q[k] = -k, BITREV = 0, out_ready = 1 -> 16 samples out_R = 0..15, out_Q = 0..-15, out_last only on the 16th, then out_valid = 0.
REQ-022 SHALL pass this scenario: BITREV = 1 with the same bundle -> out_idx/out_R sequence 0, 8, 4, 12, 2, 10, ..., 15.
REQ-023 SHALL pass this scenario: three bundles offered back-to-back with out_ready = 1 -> third accepted only after the first drains, 48 contiguous out_valid cycles, ovf = 0.
REQ-024 SHALL pass this scenario: out_ready low for 5 cycles at sample 3 -> out_R holds 3 for those cycles and cnt does not advance.
REQ-025 SHALL pass this scenario: both slots full and in_valid = 1 -> ovf = 1, stored data unchanged, and the next 32 outputs match the two original bundles.
REQ-026 SHALL pass this scenario: rst pulsed at sample 7 of bundle 1 with bundle 2 buffered -> out_valid = 0 and ovf = 0 immediately, with no residual output after release.

Source files
------------

// File: rtl/bf2_bundle_serializer.sv
// bf2_bundle_serializer: ping-pong buffer turning DEPTH-lane complex bundles into a serial sample stream
module bf2_bundle_serializer #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 16,
  parameter int BITREV = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WIDTH-1:0]        in_R [DEPTH],
  input  logic signed [WIDTH-1:0]        in_Q [DEPTH],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [WIDTH-1:0]        out_R,
  output logic signed [WIDTH-1:0]        out_Q,
  output logic [$clog2(DEPTH)-1:0]       out_idx,
  output logic                           out_last,
  output logic                           ovf
);
  localparam int AW = $clog2(DEPTH);
  logic signed [WIDTH-1:0] mem_r [2][DEPTH];
  logic signed [WIDTH-1:0] mem_q [2][DEPTH];
  logic [1:0]    full;
  logic          wp, rp, wr, rd;
  logic [AW-1:0] cnt, rev;
  assign in_ready = ~&full;
  always_comb begin
    rev = '0;
    for (int i = 0; i < AW; i++) rev[i] = cnt[AW-1-i];
    wr        = in_valid && in_ready;
    out_valid = full[rp];
    out_last  = out_valid && (cnt == AW'(DEPTH-1));
    rd        = out_valid && out_ready;
    out_idx   = (BITREV != 0) ? rev : cnt;
    out_R     = out_valid ? mem_r[rp][out_idx] : '0;
    out_Q     = out_valid ? mem_q[rp][out_idx] : '0;
  end
  // a write targets the empty slot and a final read frees the other, so both may update on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < DEPTH; k++) begin
          mem_r[s][k] <= '0;
          mem_q[s][k] <= '0;
        end
    end else begin
      if (in_valid && !in_ready) ovf <= 1'b1;
      if (wr) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_r[wp][k] <= in_R[k];
          mem_q[wp][k] <= in_Q[k];
        end
        full[wp] <= 1'b1;
        wp       <= ~wp;
      end
      if (rd) begin
        cnt <= out_last ? '0 : cnt + AW'(1);
        if (out_last) begin
          full[rp] <= 1'b0;
          rp       <= ~rp;
        end
      end
    end
  end
endmodule

// File: tb/tb_bf2_bundle_serializer.sv
// tb_bf2_bundle_serializer: scoreboard bench driving natural-order and bit-reversed instances in lockstep
module tb_bf2_bundle_serializer;
  typedef struct {
    int idx;
    int r;
    int q;
    bit last;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic signed [9:0] in_R [16];
  logic signed [9:0] in_Q [16];
  logic in_ready0, out_valid0, out_last0, ovf0;
  logic in_ready1, out_valid1, out_last1, ovf1;
  logic signed [9:0] out_R0, out_Q0, out_R1, out_Q1;
  logic [3:0] out_idx0, out_idx1;
  exp_t sb [2][$];
  int rev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int checks = 0;
  int errors = 0;
  int run = 0;
  int last_run = 0;

  always #5 clk = ~clk;

  bf2_bundle_serializer #(.WIDTH(10), .DEPTH(16), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_R(in_R), .in_Q(in_Q), .out_valid(out_valid0), .out_ready(out_ready),
    .out_R(out_R0), .out_Q(out_Q0), .out_idx(out_idx0), .out_last(out_last0), .ovf(ovf0)
  );
  bf2_bundle_serializer #(.WIDTH(10), .DEPTH(16), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_R(in_R), .in_Q(in_Q), .out_valid(out_valid1), .out_ready(out_ready),
    .out_R(out_R1), .out_Q(out_Q1), .out_idx(out_idx1), .out_last(out_last1), .ovf(ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input int d, input bit v, input int idx, input int r, input int q, input bit last);
    exp_t e;
    if (v && out_ready) begin
      if (sb[d].size() == 0) chk($sformatf("pending%0d", d), sb[d].size(), 1);
      else begin
        e = sb[d].pop_front();
        chk($sformatf("idx%0d", d), idx, e.idx);
        chk($sformatf("R%0d", d), r, e.r);
        chk($sformatf("Q%0d", d), q, e.q);
        chk($sformatf("last%0d", d), int'(last), int'(e.last));
      end
    end else if (!v) begin
      chk($sformatf("idle_R%0d", d), r, 0);
      chk($sformatf("idle_Q%0d", d), q, 0);
      chk($sformatf("idle_last%0d", d), int'(last), 0);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      check_out(0, out_valid0, int'(out_idx0), int'(out_R0), int'(out_Q0), out_last0);
      check_out(1, out_valid1, int'(out_idx1), int'(out_R1), int'(out_Q1), out_last1);
      if (out_valid0) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  endtask

  task automatic load(input int br, input int sr, input int bq, input int sq);
    for (int k = 0; k < 16; k++) begin
      in_R[k] = 10'(br + k * sr);
      in_Q[k] = 10'(bq + k * sq);
    end
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input int br, input int sr, input int bq, input int sq);
    int t = 0;
    while (!in_ready0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_ready", int'(in_ready0), 1);
    load(br, sr, bq, sq);
    in_valid = 1'b1;
    for (int p = 0; p < 16; p++) begin
      sb[0].push_back('{p, br + p * sr, bq + p * sq, p == 15});
      sb[1].push_back('{rev[p], br + rev[p] * sr, bq + rev[p] * sq, p == 15});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", sb[0].size() + sb[1].size(), 0);
    @(negedge clk);
    chk("drained_valid0", int'(out_valid0), 0);
    chk("drained_valid1", int'(out_valid1), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    load(0, 0, 0, 0);
    fork monitor(); join_none
    #12;
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_out_idx", int'(out_idx0), 0);
    chk("rst_out_last", int'(out_last1), 0);
    chk("rst_ovf", int'(ovf0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // ramp bundle, natural and bit-reversed order
    send(0, 1, 0, -1);
    drain();
    chk("single_run", last_run, 16);
    // three bundles back-to-back, including extreme signed values
    send(20, 1, -20, -1);
    send(-200, 3, 50, 2);
    send(511, -1, -512, 1);
    drain();
    chk("burst_run", last_run, 48);
    chk("burst_ovf0", int'(ovf0), 0);
    chk("burst_ovf1", int'(ovf1), 0);
    // stall at sample 3
    send(0, 1, 0, -1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_R0", int'(out_R0), 3);
      chk("hold_idx0", int'(out_idx0), 3);
      chk("hold_R1", int'(out_R1), 12);
      chk("hold_Q1", int'(out_Q1), -12);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    // overflow with both slots full
    out_ready = 1'b0;
    send(-100, -2, 100, 5);
    send(300, 7, -300, -9);
    chk("full_in_ready", int'(in_ready0), 0);
    load(7, 0, 7, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovf0_set", int'(ovf0), 1);
    chk("ovf1_set", int'(ovf1), 1);
    chk("ovf_keep_R", int'(out_R0), -100);
    out_ready = 1'b1;
    drain();
    chk("ovf_sticky", int'(ovf0), 1);
    // reset at sample 7 with a second bundle buffered
    send(40, 2, -40, -2);
    send(-7, 1, 9, 1);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb[0].delete();
    sb[1].delete();
    chk("mid_rst_valid0", int'(out_valid0), 0);
    chk("mid_rst_valid1", int'(out_valid1), 0);
    chk("mid_rst_ovf", int'(ovf0), 0);
    chk("mid_rst_in_ready", int'(in_ready0), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_residual", int'(out_valid0 | out_valid1), 0);
    end
    @(posedge clk); #1;
    send(5, -3, -5, 3);
    drain();
    chk("final_sb0", sb[0].size(), 0);
    chk("final_sb1", sb[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
